// File: rtl/sm_arb_pkg.sv
// sm_arb_pkg
//   Shared definitions for the shared-memory arbiter:
//   - default parameter values for sm_arbiter
//   - sequencer state encoding
//   - core_slice(): pulls the ADDR_W / DATA_W field of one core out of a
//     flattened per-core bus (slice i belongs to core i)
package sm_arb_pkg;

    localparam int N_CORES_DEF = 16;
    localparam int ADDR_W_DEF  = 12;
    localparam int DATA_W_DEF  = 8;
    localparam int MEM_LAT_DEF = 1;

    localparam int GRANT_ID_W  = 4;
    // Wide enough to hold MEM_LAT-1 for MEM_LAT up to 4.
    localparam int LAT_CNT_W   = 3;

    // Flattened buses are zero-padded to this width before slicing so a single
    // non-parameterised function can serve every width combination.
    localparam int SLICE_MAX_W = 32;
    localparam int BUS_MAX_W   = 16 * SLICE_MAX_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } sm_state_t;

    function automatic logic [SLICE_MAX_W-1:0] core_slice(
        input logic [BUS_MAX_W-1:0] bus,
        input int                   idx,
        input int                   width
    );
        logic [BUS_MAX_W-1:0]   shifted;
        logic [SLICE_MAX_W-1:0] res;
        shifted = bus >> (idx * width);
        res     = '0;
        for (int b = 0; b < SLICE_MAX_W; b++) begin
            if (b < width) res[b] = shifted[b];
        end
        return res;
    endfunction

endpackage

// File: rtl/sm_arbiter_rr_picker.sv
// rr_picker
//   Combinational round-robin priority encoder. Searches req upward from
//   ptr with wrap-around; the first set bit wins.
//   Ports:
//     req   in  N      request vector
//     ptr   in  PTR_W  search start position
//     found out 1      at least one request set
//     idx   out PTR_W  index of the winning request (0 when found = 0)
//   N must be a power of two so the wrap is a plain PTR_W-bit overflow.
module rr_picker #(
    parameter int N     = 16,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic             found,
    output logic [PTR_W-1:0] idx
);

    logic [PTR_W-1:0] cand;

    // Walk offsets from the far end down to 0 so the smallest offset from
    // ptr is the last assignment and therefore the winner.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = ptr + PTR_W'(k);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/sm_arbiter.sv
// sm_arbiter
//   Round-robin arbiter / sequencer that serialises one outstanding load or
//   store per core onto a single synchronous shared-memory (SM) port, and
//   returns a one-cycle completion pulse plus load data to the served core.
//   Optional build macro: SM_ARB_STATS_EN adds the stat_grants / stat_wait
//   saturating counters and their ports.
//   Ports:
//     clk, reset   clock, asynchronous active-high reset
//     core_req     per-core request level, held until that core's core_val
//     core_we      per-core op (1 = store), sampled at grant
//     core_addr    per-core address, slice i = core i, sampled at grant
//     core_wdata   per-core store data, sampled at grant
//     core_val     one-hot completion pulse
//     core_rdata   load data, valid with core_val
//     sm_en/sm_we/sm_addr/sm_wdata  SM access, one strobe per transaction
//     sm_rdata     SM read data, MEM_LAT cycles after the sm_en cycle
//     grant_id     index of the current or last granted core
//     busy         transaction in flight
//     stat_grants  (SM_ARB_STATS_EN) completed transactions, saturating
//     stat_wait    (SM_ARB_STATS_EN) cycles with an ungranted request pending
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no transaction; pick a winner and latch its request
//   ST_ISSUE | sm_en strobe cycle for the latched access
//   ST_WAIT  | MEM_LAT cycles of SM latency; last cycle captures load data
//   ST_RESP  | core_val pulse to the granted core; advance rr_ptr
module sm_arbiter
    import sm_arb_pkg::*;
#(
    parameter int N_CORES = N_CORES_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int MEM_LAT = MEM_LAT_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_CORES-1:0]          core_req,
    input  logic [N_CORES-1:0]          core_we,
    input  logic [N_CORES*ADDR_W-1:0]   core_addr,
    input  logic [N_CORES*DATA_W-1:0]   core_wdata,
    output logic [N_CORES-1:0]          core_val,
    output logic [DATA_W-1:0]           core_rdata,
    output logic                        sm_en,
    output logic                        sm_we,
    output logic [ADDR_W-1:0]           sm_addr,
    output logic [DATA_W-1:0]           sm_wdata,
    input  logic [DATA_W-1:0]           sm_rdata,
    output logic [GRANT_ID_W-1:0]       grant_id,
    output logic                        busy
`ifdef SM_ARB_STATS_EN
    ,
    output logic [15:0]                 stat_grants,
    output logic [15:0]                 stat_wait
`endif
);

    localparam int PTR_W = $clog2(N_CORES);

    sm_state_t              state, state_d;
    logic [PTR_W-1:0]       rr_ptr, rr_ptr_d;
    logic [PTR_W-1:0]       cur_idx, cur_idx_d;
    logic                   cur_we, cur_we_d;
    logic [LAT_CNT_W-1:0]   lat_cnt, lat_cnt_d;

    logic                   sm_en_d, sm_we_d;
    logic [ADDR_W-1:0]      sm_addr_d;
    logic [DATA_W-1:0]      sm_wdata_d;
    logic [N_CORES-1:0]     core_val_d;
    logic [DATA_W-1:0]      core_rdata_d;
    logic [GRANT_ID_W-1:0]  grant_id_d;
    logic                   busy_d;

    logic                   pick_found;
    logic [PTR_W-1:0]       pick_idx;
    logic [BUS_MAX_W-1:0]   addr_bus, wdata_bus;
    logic [ADDR_W-1:0]      addr_sel;
    logic [DATA_W-1:0]      wdata_sel;

    rr_picker #(
        .N     (N_CORES),
        .PTR_W (PTR_W)
    ) u_rr_picker (
        .req   (core_req),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign addr_bus  = BUS_MAX_W'(core_addr);
    assign wdata_bus = BUS_MAX_W'(core_wdata);
    assign addr_sel  = ADDR_W'(core_slice(addr_bus, int'(pick_idx), ADDR_W));
    assign wdata_sel = DATA_W'(core_slice(wdata_bus, int'(pick_idx), DATA_W));

    always_comb begin
        state_d      = state;
        rr_ptr_d     = rr_ptr;
        cur_idx_d    = cur_idx;
        cur_we_d     = cur_we;
        lat_cnt_d    = lat_cnt;
        sm_en_d      = 1'b0;
        sm_we_d      = 1'b0;
        sm_addr_d    = '0;
        sm_wdata_d   = '0;
        core_val_d   = '0;
        core_rdata_d = core_rdata;
        grant_id_d   = grant_id;

        case (state)
            ST_IDLE: begin
                // The SM bus registers double as the request latch: they are
                // loaded at grant and presented during ISSUE.
                if (pick_found) begin
                    state_d    = ST_ISSUE;
                    cur_idx_d  = pick_idx;
                    cur_we_d   = core_we[pick_idx];
                    grant_id_d = GRANT_ID_W'(pick_idx);
                    sm_en_d    = 1'b1;
                    sm_we_d    = core_we[pick_idx];
                    sm_addr_d  = addr_sel;
                    sm_wdata_d = wdata_sel;
                end
            end
            ST_ISSUE: begin
                state_d   = ST_WAIT;
                lat_cnt_d = LAT_CNT_W'(MEM_LAT - 1);
            end
            ST_WAIT: begin
                if (lat_cnt == '0) begin
                    state_d    = ST_RESP;
                    core_val_d = N_CORES'(1) << cur_idx;
                    if (!cur_we) core_rdata_d = sm_rdata;
                end else begin
                    lat_cnt_d = lat_cnt - LAT_CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d  = ST_IDLE;
                rr_ptr_d = cur_idx + PTR_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            rr_ptr     <= '0;
            cur_idx    <= '0;
            cur_we     <= 1'b0;
            lat_cnt    <= '0;
            sm_en      <= 1'b0;
            sm_we      <= 1'b0;
            sm_addr    <= '0;
            sm_wdata   <= '0;
            core_val   <= '0;
            core_rdata <= '0;
            grant_id   <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_d;
            rr_ptr     <= rr_ptr_d;
            cur_idx    <= cur_idx_d;
            cur_we     <= cur_we_d;
            lat_cnt    <= lat_cnt_d;
            sm_en      <= sm_en_d;
            sm_we      <= sm_we_d;
            sm_addr    <= sm_addr_d;
            sm_wdata   <= sm_wdata_d;
            core_val   <= core_val_d;
            core_rdata <= core_rdata_d;
            grant_id   <= grant_id_d;
            busy       <= busy_d;
        end
    end

`ifdef SM_ARB_STATS_EN
    logic [N_CORES-1:0] granted_mask;
    logic               any_waiting;

    // A core counts as granted from ISSUE through RESP; in IDLE every set
    // request is still waiting.
    always_comb begin
        granted_mask = '0;
        if (state != ST_IDLE) granted_mask = N_CORES'(1) << cur_idx;
        any_waiting = |(core_req & ~granted_mask);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_grants <= '0;
            stat_wait   <= '0;
        end else begin
            if (state == ST_RESP && stat_grants != 16'hFFFF)
                stat_grants <= stat_grants + 16'd1;
            if (any_waiting && stat_wait != 16'hFFFF)
                stat_wait <= stat_wait + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sm_arbiter.sv
// tb_sm_arbiter
//   Directed and randomized bench for sm_arbiter. u_dut uses MEM_LAT = 1,
//   u_dut4 uses MEM_LAT = 4. Each has its own behavioural SM memory; the
//   expected grant order and load data come from a transaction-level model
//   (pending set + rotating pointer + reference memory).
module tb_sm_arbiter;

   localparam int N    = 16;
   localparam int AW   = 12;
   localparam int DW   = 8;
   localparam int LAT  = 1;
   localparam int LAT4 = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   logic [N-1:0]    core_req, core_we, core_val;
   logic [N*AW-1:0] core_addr;
   logic [N*DW-1:0] core_wdata;
   logic [DW-1:0]   core_rdata, sm_wdata, sm_rdata;
   logic            sm_en, sm_we, busy;
   logic [AW-1:0]   sm_addr;
   logic [3:0]      grant_id;
`ifdef SM_ARB_STATS_EN
   logic [15:0]     stat_grants, stat_wait, stat_grants_4, stat_wait_4;
`endif

   sm_arbiter #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) u_dut (
      .clk(clk), .reset(reset),
      .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
      .core_wdata(core_wdata), .core_val(core_val), .core_rdata(core_rdata),
      .sm_en(sm_en), .sm_we(sm_we), .sm_addr(sm_addr), .sm_wdata(sm_wdata),
      .sm_rdata(sm_rdata), .grant_id(grant_id), .busy(busy)
`ifdef SM_ARB_STATS_EN
      , .stat_grants(stat_grants), .stat_wait(stat_wait)
`endif
   );

   logic [N-1:0]    core_req_4, core_we_4, core_val_4;
   logic [N*AW-1:0] core_addr_4;
   logic [N*DW-1:0] core_wdata_4;
   logic [DW-1:0]   core_rdata_4, sm_wdata_4, sm_rdata_4;
   logic            sm_en_4, sm_we_4, busy_4;
   logic [AW-1:0]   sm_addr_4;
   logic [3:0]      grant_id_4;

   sm_arbiter #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT4)) u_dut4 (
      .clk(clk), .reset(reset),
      .core_req(core_req_4), .core_we(core_we_4), .core_addr(core_addr_4),
      .core_wdata(core_wdata_4), .core_val(core_val_4), .core_rdata(core_rdata_4),
      .sm_en(sm_en_4), .sm_we(sm_we_4), .sm_addr(sm_addr_4), .sm_wdata(sm_wdata_4),
      .sm_rdata(sm_rdata_4), .grant_id(grant_id_4), .busy(busy_4)
`ifdef SM_ARB_STATS_EN
      , .stat_grants(stat_grants_4), .stat_wait(stat_wait_4)
`endif
   );

   function automatic logic [7:0] init_val(input logic [11:0] a);
      if (a == 12'h2A5) return 8'h5C;
      if (a == 12'h123) return 8'hA9;
      return a[7:0] ^ {a[11:8], a[3:0]} ^ 8'h3B;
   endfunction

   logic [7:0] mem1 [4096];
   bit         wr1  [4096];
   logic [7:0] mem4 [4096];
   bit         wr4  [4096];
   logic [7:0] rd1;
   logic [7:0] rd4 [4];

   always @(posedge clk) begin
      if (sm_en && sm_we) begin
         mem1[sm_addr] <= sm_wdata;
         wr1[sm_addr]  <= 1'b1;
      end
      if (sm_en && !sm_we) rd1 <= wr1[sm_addr] ? mem1[sm_addr] : init_val(sm_addr);
      else                 rd1 <= 8'($urandom);
   end
   assign sm_rdata = rd1;

   always @(posedge clk) begin
      if (sm_en_4 && sm_we_4) begin
         mem4[sm_addr_4] <= sm_wdata_4;
         wr4[sm_addr_4]  <= 1'b1;
      end
      if (sm_en_4 && !sm_we_4) rd4[0] <= wr4[sm_addr_4] ? mem4[sm_addr_4] : init_val(sm_addr_4);
      else                     rd4[0] <= 8'($urandom);
      for (int i = 1; i < 4; i++) rd4[i] <= rd4[i-1];
   end
   assign sm_rdata_4 = rd4[3];

   logic [7:0]    ref_mem [4096];
   bit            pend    [N];
   logic          op_we   [N];
   logic [AW-1:0] op_addr [N];
   logic [DW-1:0] op_wd   [N];
   int            mptr;

   task automatic fail(input string tag);
      failures++;
      $error("FAIL %s", tag);
   endtask

   task automatic post(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
      op_we[i] = we; op_addr[i] = a; op_wd[i] = wd; pend[i] = 1'b1;
      core_we[i] = we;
      core_addr[i*AW +: AW]  = a;
      core_wdata[i*DW +: DW] = wd;
      core_req[i] = 1'b1;
   endtask

   function automatic int next_winner();
      for (int k = 0; k < N; k++)
         if (pend[(mptr + k) % N]) return (mptr + k) % N;
      return -1;
   endfunction

   task automatic run_txn(input int g, output int en_cyc, output int val_cyc);
      logic [DW-1:0] exp_rd;
      bit seen;
      exp_rd  = ref_mem[op_addr[g]];
      seen    = 1'b0;
      en_cyc  = -1;
      val_cyc = -1;
      for (int k = 0; k < 40 && !seen; k++) begin
         @(negedge clk);
         if (sm_en === 1'b1) begin seen = 1'b1; en_cyc = cyc; end
      end
      checks++; if (seen !== 1'b1) fail("sm_en_seen");
      if (!seen) return;
      checks++; if (grant_id !== 4'(g)) fail("grant_id");
      checks++; if (sm_we !== op_we[g]) fail("sm_we");
      checks++; if (sm_addr !== op_addr[g]) fail("sm_addr");
      if (op_we[g]) begin
         checks++; if (sm_wdata !== op_wd[g]) fail("sm_wdata");
      end
      checks++; if (busy !== 1'b1) fail("busy");
      core_we[g] = 1'($urandom_range(0, 1));
      core_addr[g*AW +: AW]  = AW'($urandom);
      core_wdata[g*DW +: DW] = DW'($urandom);
      @(negedge clk);
      checks++; if (sm_en !== 1'b0) fail("sm_en_one_cycle");
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         if (core_val !== '0) begin seen = 1'b1; val_cyc = cyc; end
         else @(negedge clk);
      end
      checks++; if (seen !== 1'b1) fail("core_val_seen");
      if (!seen) return;
      checks++; if (core_val !== (N'(1) << g)) fail("core_val");
      checks++; if ((val_cyc - en_cyc) !== (LAT + 1)) fail("en_to_val");
      if (!op_we[g]) begin
         checks++; if (core_rdata !== exp_rd) fail("core_rdata");
      end else begin
         ref_mem[op_addr[g]] = op_wd[g];
      end
      pend[g] = 1'b0;
      mptr = (g + 1) % N;
      @(posedge clk); #1;
      core_req[g] = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int en_c, val_c, req_c, prev_val, g;
      int order [6];
      bit seen;

      order = '{0, 5, 15, 0, 5, 15};
      for (int a = 0; a < 4096; a++) ref_mem[a] = init_val(12'(a));
      for (int i = 0; i < N; i++) begin pend[i] = 1'b0; op_we[i] = 1'b0; op_addr[i] = '0; op_wd[i] = '0; end
      mptr = 0;
      reset = 1'b1;
      core_req = '0; core_we = '0; core_addr = '0; core_wdata = '0;
      core_req_4 = '0; core_we_4 = '0; core_addr_4 = '0; core_wdata_4 = '0;

      repeat (3) @(negedge clk);
      checks++; if (core_val !== '0) fail("rst_core_val");
      checks++; if (core_rdata !== '0) fail("rst_core_rdata");
      checks++; if (sm_en !== 1'b0) fail("rst_sm_en");
      checks++; if (sm_we !== 1'b0) fail("rst_sm_we");
      checks++; if (sm_addr !== '0) fail("rst_sm_addr");
      checks++; if (sm_wdata !== '0) fail("rst_sm_wdata");
      checks++; if (grant_id !== '0) fail("rst_grant_id");
      checks++; if (busy !== 1'b0) fail("rst_busy");
      reset = 1'b0;
      @(posedge clk); #1;

      post(3, 1'b0, 12'h2A5, 8'h00);
      req_c = cyc;
      run_txn(3, en_c, val_c);
      checks++; if ((en_c - req_c) !== 1) fail("load_req_to_en");
      checks++; if ((val_c - req_c) !== 3) fail("load_req_to_val");
      checks++; if (core_rdata !== 8'h5C) fail("load_data_5c");

      post(0, 1'b1, 12'h010, 8'h77);
      run_txn(0, en_c, val_c);
      post(15, 1'b0, 12'h010, 8'h00);
      run_txn(15, en_c, val_c);
      checks++; if (core_rdata !== 8'h77) fail("store_readback");

      post(0, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
      post(5, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
      post(15, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
      for (int j = 0; j < 6; j++) begin
         run_txn(order[j], en_c, val_c);
         if (j < 3) post(order[j], 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
      end

      post(14, 1'b0, AW'($urandom), 8'h00);
      run_txn(14, en_c, val_c);
      post(15, 1'b1, 12'h300, 8'h3D);
      post(1, 1'b0, 12'h2A5, 8'h00);
      run_txn(15, en_c, val_c);
      run_txn(1, en_c, val_c);

      post(7, 1'b0, 12'h3C0, 8'h00);
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         @(negedge clk);
         if (sm_en === 1'b1) seen = 1'b1;
      end
      checks++; if (seen !== 1'b1) fail("rst_mid_en_seen");
      post(1, 1'b0, 12'h123, 8'h00);
      @(negedge clk);
      checks++; if (busy !== 1'b1) fail("rst_mid_busy_before");
      reset = 1'b1;
      #1;
      checks++; if (core_val !== '0) fail("rst_mid_core_val");
      checks++; if (core_rdata !== '0) fail("rst_mid_core_rdata");
      checks++; if (sm_en !== 1'b0) fail("rst_mid_sm_en");
      checks++; if (grant_id !== '0) fail("rst_mid_grant_id");
      checks++; if (busy !== 1'b0) fail("rst_mid_busy");
      @(negedge clk);
      reset = 1'b0;
      mptr = 0;
      run_txn(1, en_c, val_c);
      run_txn(7, en_c, val_c);

      prev_val = 0;
      for (int t = 0; t < 80; t++) begin
         for (int i = 0; i < N; i++) begin
            if (pend[i] && $urandom_range(0, 15) == 0) begin
               pend[i] = 1'b0;
               core_req[i] = 1'b0;
            end else if (!pend[i] && $urandom_range(0, 3) == 0) begin
               post(i, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
            end
         end
         if (next_winner() < 0)
            post($urandom_range(0, N - 1), 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
         g = next_winner();
         run_txn(g, en_c, val_c);
         if (t > 0) begin
            checks++; if ((en_c - prev_val) !== 2) fail("rand_back_to_back");
         end
         prev_val = val_c;
      end

      @(posedge clk); #1;
      core_req_4[2] = 1'b1;
      core_we_4[2]  = 1'b0;
      core_addr_4[2*AW +: AW] = 12'h123;
      req_c = cyc;
      @(posedge clk); #1;
      core_addr_4[2*AW +: AW]  = 12'hFFF;
      core_we_4[2]             = 1'b1;
      core_wdata_4[2*DW +: DW] = 8'h11;
      @(negedge clk);
      checks++; if (sm_en_4 !== 1'b1) fail("lat4_sm_en");
      checks++; if (sm_addr_4 !== 12'h123) fail("lat4_sm_addr");
      checks++; if (sm_we_4 !== 1'b0) fail("lat4_sm_we");
      checks++; if (grant_id_4 !== 4'd2) fail("lat4_grant_id");
      seen = 1'b0;
      val_c = -1;
      for (int k = 0; k < 12 && !seen; k++) begin
         @(negedge clk);
         if (core_val_4 !== '0) begin seen = 1'b1; val_c = cyc; end
      end
      checks++; if (seen !== 1'b1) fail("lat4_val_seen");
      checks++; if ((val_c - req_c) !== 6) fail("lat4_req_to_val");
      checks++; if (core_val_4 !== 16'h0004) fail("lat4_core_val");
      checks++; if (core_rdata_4 !== 8'hA9) fail("lat4_core_rdata");
      @(posedge clk); #1;
      core_req_4[2] = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (busy_4 !== 1'b0) fail("lat4_idle_busy");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
